// File: rtl/inst_buffer_pkg.sv
// Shared types, MIPS opcode fields and branch-type codes for the instruction buffer.
// An entry is branch-predecoded once on entry and the result is stored alongside it.
package ibuf_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FUN_JR     = 6'h08;
  localparam logic [5:0] FUN_JALR   = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  typedef enum logic [3:0] {
    BT_NOP   = 4'd0,
    BT_J     = 4'd1,
    BT_JREG  = 4'd2,
    BT_BEQ   = 4'd3,
    BT_BNE   = 4'd4,
    BT_BGTZ  = 4'd5,
    BT_BLEZ  = 4'd6,
    BT_BGEZ_ = 4'd7,
    BT_BLTZ_ = 4'd8
  } branch_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  branch_type;
    logic        is_link_pc8;
  } ibuf_entry_t;

  // Length of the run of ones starting at bit 0; equals popcount for a thermometer code.
  function automatic logic [2:0] popcount_thermo(input logic [3:0] v);
    logic [2:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run = run & v[i];
      n   = n + {2'b00, run};
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side push lanes, decode-side head view and occupancy status of the instruction buffer.
interface inst_buffer_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int POP_W = $clog2(ISSUE_WIDTH + 1);

  logic                        flush;
  logic [FETCH_WIDTH-1:0]      in_valid;
  logic [32*FETCH_WIDTH-1:0]   in_instr;
  logic [32*FETCH_WIDTH-1:0]   in_pc;
  logic                        in_ready;
  logic [ISSUE_WIDTH-1:0]      out_valid;
  logic [32*ISSUE_WIDTH-1:0]   out_instr;
  logic [32*ISSUE_WIDTH-1:0]   out_pc;
  logic [4*ISSUE_WIDTH-1:0]    out_branch_type;
  logic [ISSUE_WIDTH-1:0]      out_is_link_pc8;
  logic [POP_W-1:0]            pop_cnt;
  logic [CNT_W-1:0]            count;
  logic                        empty;

  modport master (
    output flush, in_valid, in_instr, in_pc, pop_cnt,
    input  in_ready, out_valid, out_instr, out_pc, out_branch_type,
           out_is_link_pc8, count, empty
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, pop_cnt,
    output in_ready, out_valid, out_instr, out_pc, out_branch_type,
           out_is_link_pc8, count, empty
  );
endinterface

// File: rtl/inst_buffer_branch_predecode.sv
// Combinational branch predecode of one instruction into branch type and link-to-PC+8 flag.
module branch_predecode
  import ibuf_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  branch_type,
  output logic        is_link_pc8
);
  logic [5:0] op;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign rt            = instr[20:16];
  assign funct         = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  always_comb begin
    branch_type = BT_NOP;
    is_link_pc8 = 1'b0;
    case (op)
      OP_J:    branch_type = BT_J;
      OP_JAL:  begin branch_type = BT_J; is_link_pc8 = 1'b1; end
      OP_BEQ:  branch_type = BT_BEQ;
      OP_BNE:  branch_type = BT_BNE;
      OP_BLEZ: branch_type = BT_BLEZ;
      OP_BGTZ: branch_type = BT_BGTZ;
      OP_SPECIAL: begin
        if (funct == FUN_JR) begin
          branch_type = BT_JREG;
        end else if (funct == FUN_JALR) begin
          branch_type = BT_JREG;
          is_link_pc8 = 1'b1;
        end
      end
      OP_REGIMM: begin
        case (rt)
          RT_BGEZ:   branch_type = BT_BGEZ_;
          RT_BLTZ:   branch_type = BT_BLTZ_;
          RT_BGEZAL: begin branch_type = BT_BGEZ_; is_link_pc8 = 1'b1; end
          RT_BLTZAL: begin branch_type = BT_BLTZ_; is_link_pc8 = 1'b1; end
          default:   ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and decode; head lanes are held back so a
// branch is never issued without its delay slot.
module inst_buffer
  import ibuf_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  inst_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_WIDTH);

  ibuf_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count_q;

  logic [3:0]         lane_bt   [FETCH_WIDTH];
  logic               lane_link [FETCH_WIDTH];

  logic               push_en;
  logic [2:0]         push_n;
  logic [2:0]         pop_avail;
  logic [2:0]         pop_req;
  logic [2:0]         pop_n;

  logic [ISSUE_WIDTH-1:0]    valid_v;
  logic [32*ISSUE_WIDTH-1:0] instr_v;
  logic [32*ISSUE_WIDTH-1:0] pc_v;
  logic [4*ISSUE_WIDTH-1:0]  bt_v;
  logic [ISSUE_WIDTH-1:0]    link_v;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_pd
    branch_predecode u_pd (
      .instr       (bus.in_instr[32*g +: 32]),
      .branch_type (lane_bt[g]),
      .is_link_pc8 (lane_link[g])
    );
  end

  // Ready depends on registered count only, so pops never open a same-cycle push slot.
  assign bus.in_ready = (count_q <= READY_MAX);
  assign push_en      = bus.in_ready && bus.in_valid[0];
  assign push_n       = push_en ? popcount_thermo(4'(bus.in_valid)) : 3'd0;

  always_comb begin
    logic        chain;
    logic        issuable;
    ibuf_entry_t ent;
    chain    = 1'b1;
    issuable = 1'b0;
    ent      = '0;
    valid_v  = '0;
    instr_v  = '0;
    pc_v     = '0;
    bt_v     = '0;
    link_v   = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      ent      = mem[head + PTR_W'(k)];
      issuable = (count_q > CNT_W'(k)) &&
                 ((ent.branch_type == BT_NOP) || (count_q >= CNT_W'(k + 2)));
      chain    = chain & issuable;
      if (chain) begin
        valid_v[k]           = 1'b1;
        instr_v[32*k +: 32]  = ent.instr;
        pc_v[32*k +: 32]     = ent.pc;
        bt_v[4*k +: 4]       = ent.branch_type;
        link_v[k]            = ent.is_link_pc8;
      end
    end
  end

  assign pop_avail = popcount_thermo(4'(valid_v));
  assign pop_req   = 3'(bus.pop_cnt);
  assign pop_n     = (pop_req < pop_avail) ? pop_req : pop_avail;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(pop_n);
      tail    <= tail + PTR_W'(push_n);
      count_q <= count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // Storage needs no reset: lanes beyond count are masked to zero on the read side.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (3'(k) < push_n) begin
          mem[tail + PTR_W'(k)] <= '{pc:          bus.in_pc[32*k +: 32],
                                     instr:       bus.in_instr[32*k +: 32],
                                     branch_type: lane_bt[k],
                                     is_link_pc8: lane_link[k]};
        end
      end
    end
  end

  assign bus.out_valid       = valid_v;
  assign bus.out_instr       = instr_v;
  assign bus.out_pc          = pc_v;
  assign bus.out_branch_type = bt_v;
  assign bus.out_is_link_pc8 = link_v;
  assign bus.count           = count_q;
  assign bus.empty           = (count_q == '0);
endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: directed pushes queue expected entries, a negedge monitor
// compares the head view against the queue and retires entries as they are popped.
module tb_inst_buffer;
  import ibuf_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  bt;
    logic        link;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_buffer_if #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(16)) bus ();

  inst_buffer #(.DEPTH(16), .FETCH_WIDTH(2), .ISSUE_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [3:0] bt, input logic link);
    exp_t e;
    e.pc = pc; e.instr = instr; e.bt = bt; e.link = link;
    return e;
  endfunction

  // Called at posedge+1; returns at the following posedge+1 with the scoreboard updated.
  task automatic push_step(input exp_t a, input exp_t b, input logic [1:0] v,
                           input logic [1:0] popc, input logic fl, input logic acc);
    bus.in_valid = v;
    bus.in_instr = {b.instr, a.instr};
    bus.in_pc    = {b.pc, a.pc};
    bus.pop_cnt  = popc;
    bus.flush    = fl;
    if (v[0]) check("in_ready_at_push", 64'(bus.in_ready), 64'(acc));
    @(posedge clk);
    #1;
    if (fl) sb_q.delete();
    else if (acc) begin
      if (v[0]) sb_q.push_back(a);
      if (v[1]) sb_q.push_back(b);
    end
    bus.in_valid = '0;
    bus.pop_cnt  = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic pop_step(input logic [1:0] popc);
    push_step('0, '0, 2'b00, popc, 1'b0, 1'b1);
  endtask

  // Monitor: independent model of issuability from the queued predecode results.
  always @(negedge clk) begin
    logic [1:0] mv;
    logic       prev;
    int         avail;
    int         np;
    if (!rst) begin
      mv    = '0;
      prev  = 1'b1;
      avail = 0;
      for (int k = 0; k < 2; k++) begin
        if (prev && sb_q.size() > k && (sb_q[k].bt == BT_NOP || sb_q.size() >= k + 2)) begin
          mv[k] = 1'b1;
          avail++;
        end else begin
          prev = 1'b0;
        end
      end
      check("out_valid", 64'(bus.out_valid), 64'(mv));
      check("count", 64'(bus.count), 64'(sb_q.size()));
      check("empty", 64'(bus.empty), 64'(sb_q.size() == 0));
      check("in_ready", 64'(bus.in_ready), 64'((16 - sb_q.size()) >= 2));
      for (int k = 0; k < 2; k++) begin
        if (mv[k]) begin
          check("lane_pc", 64'(bus.out_pc[32*k +: 32]), 64'(sb_q[k].pc));
          check("lane_instr", 64'(bus.out_instr[32*k +: 32]), 64'(sb_q[k].instr));
          check("lane_bt", 64'(bus.out_branch_type[4*k +: 4]), 64'(sb_q[k].bt));
          check("lane_link", 64'(bus.out_is_link_pc8[k]), 64'(sb_q[k].link));
        end else begin
          check("lane_zero", {bus.out_pc[32*k +: 32], bus.out_instr[32*k +: 32]}, 64'h0);
          check("lane_zero_bt", 64'({bus.out_branch_type[4*k +: 4], bus.out_is_link_pc8[k]}), 64'h0);
        end
      end
      if (!bus.flush) begin
        np = (int'(bus.pop_cnt) < avail) ? int'(bus.pop_cnt) : avail;
        repeat (np) void'(sb_q.pop_front());
      end
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial begin
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = '0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
    bus.pop_cnt  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_pc", bus.out_pc, 64'd0);
    rst = 1'b0;

    // Basic pair of non-branches
    push_step(mk(32'hBFC0_0000, 32'h2401_0001, BT_NOP, 1'b0),
              mk(32'hBFC0_0004, 32'h2402_0002, BT_NOP, 1'b0), 2'b11, 2'd0, 1'b0, 1'b1);
    check("pair_count", 64'(bus.count), 64'd2);
    check("pair_valid", 64'(bus.out_valid), 64'b11);
    check("pair_pc", bus.out_pc, 64'hBFC0_0004_BFC0_0000);
    check("pair_bt", 64'(bus.out_branch_type), 64'h0);
    pop_step(2'd2);
    check("pair_drained", 64'(bus.empty), 64'd1);

    // Branch held until its delay slot arrives
    push_step(mk(32'h0000_0100, 32'h1022_0003, BT_BEQ, 1'b0), '0, 2'b01, 2'd0, 1'b0, 1'b1);
    check("beq_alone_valid", 64'(bus.out_valid), 64'b00);
    check("beq_alone_count", 64'(bus.count), 64'd1);
    push_step(mk(32'h0000_0104, NOP, BT_NOP, 1'b0), '0, 2'b01, 2'd0, 1'b0, 1'b1);
    check("beq_slot_valid", 64'(bus.out_valid), 64'b11);
    check("beq_bt", 64'(bus.out_branch_type[3:0]), 64'(BT_BEQ));
    pop_step(2'd2);
    check("beq_empty", 64'(bus.empty), 64'd1);

    // Predecode of link and register jumps
    push_step(mk(32'h0000_0200, 32'h0C00_0010, BT_J, 1'b1),
              mk(32'h0000_0204, NOP, BT_NOP, 1'b0), 2'b11, 2'd0, 1'b0, 1'b1);
    check("jal_bt", 64'(bus.out_branch_type[3:0]), 64'(BT_J));
    check("jal_link", 64'(bus.out_is_link_pc8[0]), 64'd1);
    pop_step(2'd2);
    push_step(mk(32'h0000_0300, 32'h0411_0004, BT_BGEZ_, 1'b1),
              mk(32'h0000_0304, NOP, BT_NOP, 1'b0), 2'b11, 2'd0, 1'b0, 1'b1);
    check("bgezal_bt", 64'(bus.out_branch_type[3:0]), 64'(BT_BGEZ_));
    check("bgezal_link", 64'(bus.out_is_link_pc8[0]), 64'd1);
    pop_step(2'd2);
    push_step(mk(32'h0000_0400, 32'h03E0_0008, BT_JREG, 1'b0),
              mk(32'h0000_0404, NOP, BT_NOP, 1'b0), 2'b11, 2'd0, 1'b0, 1'b1);
    check("jr_bt", 64'(bus.out_branch_type[3:0]), 64'(BT_JREG));
    check("jr_link", 64'(bus.out_is_link_pc8[0]), 64'd0);
    pop_step(2'd2);
    push_step(mk(32'h0000_0500, 32'h0200_F809, BT_JREG, 1'b1),
              mk(32'h0000_0504, 32'h1440_0002, BT_BNE, 1'b0), 2'b11, 2'd0, 1'b0, 1'b1);
    pop_step(2'd2);
    check("jalr_bne_left", 64'(bus.count), 64'd1);
    push_step(mk(32'h0000_0508, NOP, BT_NOP, 1'b0), '0, 2'b01, 2'd2, 1'b0, 1'b1);
    pop_step(2'd2);
    check("jalr_bne_empty", 64'(bus.empty), 64'd1);

    // Fill to DEPTH-1, dropped push, then space reopens after a pop
    for (int i = 0; i < 7; i++) begin
      push_step(mk(32'h1000 + 32'(8*i), 32'h2400_0000 + 32'(2*i), BT_NOP, 1'b0),
                mk(32'h1004 + 32'(8*i), 32'h2400_0001 + 32'(2*i), BT_NOP, 1'b0),
                2'b11, 2'd0, 1'b0, 1'b1);
    end
    push_step(mk(32'h1038, 32'h2400_00EE, BT_NOP, 1'b0), '0, 2'b01, 2'd0, 1'b0, 1'b1);
    check("full_count", 64'(bus.count), 64'd15);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    push_step(mk(32'h1040, 32'h2400_00FF, BT_NOP, 1'b0),
              mk(32'h1044, 32'h2400_00FF, BT_NOP, 1'b0), 2'b11, 2'd0, 1'b0, 1'b0);
    check("full_drop_count", 64'(bus.count), 64'd15);
    pop_step(2'd2);
    check("after_pop_count", 64'(bus.count), 64'd13);
    check("after_pop_ready", 64'(bus.in_ready), 64'd1);
    repeat (7) pop_step(2'd2);
    check("fill_drained", 64'(bus.empty), 64'd1);

    // Pointer wrap: advance head/tail to 15, then push a pair across 15 -> 0
    push_step('0, '0, 2'b00, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      push_step(mk(32'h3000 + 32'(4*i), 32'h2400_0100 + 32'(i), BT_NOP, 1'b0), '0,
                2'b01, (i == 0) ? 2'd0 : 2'd1, 1'b0, 1'b1);
    end
    pop_step(2'd1);
    check("wrap_pre_empty", 64'(bus.empty), 64'd1);
    push_step(mk(32'h2000, 32'h2400_0011, BT_NOP, 1'b0),
              mk(32'h2004, 32'h2400_0022, BT_NOP, 1'b0), 2'b11, 2'd0, 1'b0, 1'b1);
    check("wrap_pc", bus.out_pc, 64'h0000_2004_0000_2000);
    check("wrap_instr", bus.out_instr, 64'h2400_0022_2400_0011);
    pop_step(2'd2);
    check("wrap_empty", 64'(bus.empty), 64'd1);

    // Flush wins over a simultaneous push and pop
    push_step(mk(32'h4000, NOP, BT_NOP, 1'b0), mk(32'h4004, NOP, BT_NOP, 1'b0), 2'b11, 2'd0, 1'b0, 1'b1);
    push_step(mk(32'h4008, NOP, BT_NOP, 1'b0), mk(32'h400C, NOP, BT_NOP, 1'b0), 2'b11, 2'd0, 1'b0, 1'b1);
    push_step(mk(32'h4010, NOP, BT_NOP, 1'b0), '0, 2'b01, 2'd0, 1'b0, 1'b1);
    check("preflush_count", 64'(bus.count), 64'd5);
    push_step(mk(32'h4014, NOP, BT_NOP, 1'b0), mk(32'h4018, NOP, BT_NOP, 1'b0), 2'b11, 2'd1, 1'b1, 1'b1);
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_empty", 64'(bus.empty), 64'd1);
    check("flush_valid", 64'(bus.out_valid), 64'd0);

    // pop_cnt clamped to the issuable prefix
    push_step(mk(32'h0000_0600, NOP, BT_NOP, 1'b0),
              mk(32'h0000_0604, 32'h1022_0003, BT_BEQ, 1'b0), 2'b11, 2'd0, 1'b0, 1'b1);
    check("clamp_valid", 64'(bus.out_valid), 64'b01);
    pop_step(2'd2);
    check("clamp_count", 64'(bus.count), 64'd1);
    check("clamp_hold", 64'(bus.out_valid), 64'b00);
    push_step(mk(32'h0000_0608, NOP, BT_NOP, 1'b0), '0, 2'b01, 2'd0, 1'b0, 1'b1);
    check("clamp_slot_valid", 64'(bus.out_valid), 64'b11);
    pop_step(2'd2);
    check("clamp_empty", 64'(bus.empty), 64'd1);

    pop_step(2'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
